// File: rtl/switch_pkg.sv
// Shared constants and pointer-wrap helper for the switch port FIFOs.
package switch_pkg;

  localparam int FIFO_DEPTH_DEF = 64;
  localparam int FIFO_WIDTH_DEF = 8;

  // Wraps at depth-1 so any depth works, not just powers of two.
  function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/fifo_ptr.sv
// Wrapping pointer counter with synchronous clear; one instance each for write and read.
module fifo_ptr
  import switch_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH_DEF,
  parameter int PW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          inc,
  input  logic          clr,
  output logic [PW-1:0] ptr
);

  logic [PW-1:0] r_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     r_ptr <= '0;
    else if (clr)   r_ptr <= '0;
    else if (inc)   r_ptr <= PW'(ptr_inc(32'(r_ptr), DEPTH));
  end

  assign ptr = r_ptr;

endmodule

// File: rtl/fifo_occ.sv
// Single-clock port FIFO with occupancy count, level flags, sticky errors and flush.
// Define FIFO_FWFT_EN for first-word-fall-through reads; default is a registered read.
module fifo_occ
  import switch_pkg::*;
#(
  parameter  int DEPTH    = FIFO_DEPTH_DEF,
  parameter  int W_WIDTH  = FIFO_WIDTH_DEF,
  parameter  int AF_LEVEL = 56,
  parameter  int AE_LEVEL = 8,
  localparam int CW       = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               wr_en,
  input  logic [W_WIDTH-1:0] data_in,
  input  logic               rd_en,
  output logic [W_WIDTH-1:0] data_out,
  output logic               rd_valid,
  output logic               full,
  output logic               empty,
  output logic               almost_full,
  output logic               almost_empty,
  output logic [CW-1:0]      count,
  output logic               overflow,
  output logic               underflow,
  input  logic               err_clr
);

  localparam int            PW    = $clog2(DEPTH);
  localparam logic [CW-1:0] C_DEP = CW'(DEPTH);
  localparam logic [CW-1:0] C_AF  = CW'(AF_LEVEL);
  localparam logic [CW-1:0] C_AE  = CW'(AE_LEVEL);

  logic [W_WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]      w_wr_ptr, w_rd_ptr;
  logic [CW-1:0]      r_count, w_next_count;
  logic               r_full, r_empty, r_af, r_ae, r_ovf, r_udf;
  logic               w_wr_acc, w_rd_acc, w_wr_rej, w_rd_rej;

  // A flush cycle swallows any request without accepting it or flagging an error.
  always_comb begin
    w_wr_acc     = wr_en & ~r_full  & ~flush;
    w_rd_acc     = rd_en & ~r_empty & ~flush;
    w_wr_rej     = wr_en &  r_full  & ~flush;
    w_rd_rej     = rd_en &  r_empty & ~flush;
    w_next_count = r_count;
    if (flush)                      w_next_count = '0;
    else if (w_wr_acc && !w_rd_acc) w_next_count = r_count + 1'b1;
    else if (w_rd_acc && !w_wr_acc) w_next_count = r_count - 1'b1;
  end

  fifo_ptr #(.DEPTH(DEPTH), .PW(PW)) u_wr_ptr (
    .clk(clk), .rst_n(rst_n), .inc(w_wr_acc), .clr(flush), .ptr(w_wr_ptr)
  );

  fifo_ptr #(.DEPTH(DEPTH), .PW(PW)) u_rd_ptr (
    .clk(clk), .rst_n(rst_n), .inc(w_rd_acc), .clr(flush), .ptr(w_rd_ptr)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
      r_af    <= 1'b0;
      r_ae    <= 1'b1;
    end else begin
      r_count <= w_next_count;
      r_full  <= (w_next_count == C_DEP);
      r_empty <= (w_next_count == '0);
      r_af    <= (w_next_count >= C_AF);
      r_ae    <= (w_next_count <= C_AE);
    end
  end

  // A fresh error outranks a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else begin
      r_ovf <= w_wr_rej | (r_ovf & ~err_clr);
      r_udf <= w_rd_rej | (r_udf & ~err_clr);
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_acc) r_mem[w_wr_ptr] <= data_in;
  end

`ifdef FIFO_FWFT_EN
  assign data_out = r_mem[w_rd_ptr];
  assign rd_valid = ~r_empty;
`else
  logic [W_WIDTH-1:0] r_dout;
  logic               r_rd_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dout     <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= w_rd_acc;
      if (w_rd_acc) r_dout <= r_mem[w_rd_ptr];
    end
  end

  assign data_out = r_dout;
  assign rd_valid = r_rd_valid;
`endif

  assign full         = r_full;
  assign empty        = r_empty;
  assign almost_full  = r_af;
  assign almost_empty = r_ae;
  assign count        = r_count;
  assign overflow     = r_ovf;
  assign underflow    = r_udf;

endmodule

// File: tb/tb_fifo_occ.sv
// Directed bench for fifo_occ: a 64-deep instance and a 5-deep instance, with a queue scoreboard.
module tb_fifo_occ;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       a_flush, a_wr, a_rd, a_clr;
  logic [7:0] a_din, a_dout;
  logic       a_rv, a_full, a_empty, a_af, a_ae, a_ovf, a_udf;
  logic [6:0] a_cnt;

  logic       b_flush, b_wr, b_rd, b_clr;
  logic [7:0] b_din, b_dout;
  logic       b_rv, b_full, b_empty, b_af, b_ae, b_ovf, b_udf;
  logic [2:0] b_cnt;

  fifo_occ #(.DEPTH(64), .W_WIDTH(8), .AF_LEVEL(56), .AE_LEVEL(8)) u_a (
    .clk(clk), .rst_n(rst_n), .flush(a_flush), .wr_en(a_wr), .data_in(a_din),
    .rd_en(a_rd), .data_out(a_dout), .rd_valid(a_rv), .full(a_full), .empty(a_empty),
    .almost_full(a_af), .almost_empty(a_ae), .count(a_cnt), .overflow(a_ovf),
    .underflow(a_udf), .err_clr(a_clr)
  );

  fifo_occ #(.DEPTH(5), .W_WIDTH(8), .AF_LEVEL(4), .AE_LEVEL(1)) u_b (
    .clk(clk), .rst_n(rst_n), .flush(b_flush), .wr_en(b_wr), .data_in(b_din),
    .rd_en(b_rd), .data_out(b_dout), .rd_valid(b_rv), .full(b_full), .empty(b_empty),
    .almost_full(b_af), .almost_empty(b_ae), .count(b_cnt), .overflow(b_ovf),
    .underflow(b_udf), .err_clr(b_clr)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] qa[$];
  logic [7:0] qb[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One cycle on the 64-deep instance; scoreboard decides acceptance from its own occupancy.
  task automatic a_cyc(input bit wr, input logic [7:0] din, input bit rd);
    bit         do_pop, do_push;
    logic [7:0] exp;
    exp     = 8'h00;
    do_pop  = rd && (qa.size() > 0);
    do_push = wr && (qa.size() < 64);
    if (do_pop) exp = qa[0];
    a_wr = wr; a_din = din; a_rd = rd;
`ifdef FIFO_FWFT_EN
    if (do_pop) begin
      #1;
      chk("a_fwft_data", a_dout, exp);
      chk("a_fwft_valid", a_rv, 1);
    end
`endif
    step();
    a_wr = 1'b0; a_rd = 1'b0;
    if (do_pop)  void'(qa.pop_front());
    if (do_push) qa.push_back(din);
`ifndef FIFO_FWFT_EN
    chk("a_rd_valid", a_rv, do_pop);
    if (do_pop) chk("a_data", a_dout, exp);
`endif
    chk("a_count", a_cnt, qa.size());
    chk("a_full", a_full, qa.size() == 64);
    chk("a_empty", a_empty, qa.size() == 0);
    chk("a_afull", a_af, qa.size() >= 56);
    chk("a_aempty", a_ae, qa.size() <= 8);
  endtask

  task automatic b_cyc(input bit wr, input logic [7:0] din, input bit rd);
    bit         do_pop, do_push;
    logic [7:0] exp;
    exp     = 8'h00;
    do_pop  = rd && (qb.size() > 0);
    do_push = wr && (qb.size() < 5);
    if (do_pop) exp = qb[0];
    b_wr = wr; b_din = din; b_rd = rd;
`ifdef FIFO_FWFT_EN
    if (do_pop) begin
      #1;
      chk("b_fwft_data", b_dout, exp);
    end
`endif
    step();
    b_wr = 1'b0; b_rd = 1'b0;
    if (do_pop)  void'(qb.pop_front());
    if (do_push) qb.push_back(din);
`ifndef FIFO_FWFT_EN
    chk("b_rd_valid", b_rv, do_pop);
    if (do_pop) chk("b_data", b_dout, exp);
`endif
    chk("b_count", b_cnt, qb.size());
    chk("b_full", b_full, qb.size() == 5);
    chk("b_empty", b_empty, qb.size() == 0);
  endtask

  initial begin
    rst_n = 1'b0;
    a_flush = 0; a_wr = 0; a_rd = 0; a_clr = 0; a_din = 8'h00;
    b_flush = 0; b_wr = 0; b_rd = 0; b_clr = 0; b_din = 8'h00;
    step(); step();

    chk("rst_count", a_cnt, 0);
    chk("rst_empty", a_empty, 1);
    chk("rst_aempty", a_ae, 1);
    chk("rst_full", a_full, 0);
    chk("rst_afull", a_af, 0);
    chk("rst_valid", a_rv, 0);
    chk("rst_ovf", a_ovf, 0);
    chk("rst_udf", a_udf, 0);
`ifndef FIFO_FWFT_EN
    chk("rst_dout", a_dout, 0);
`endif
    rst_n = 1'b1;
    step();

    // Fill 0x00..0x3F.
    for (int i = 0; i < 64; i++) a_cyc(1'b1, 8'(i), 1'b0);

    // Write while full: rejected, memory untouched (head must still read 0x00).
    a_cyc(1'b1, 8'hAA, 1'b0);
    chk("ovf_set", a_ovf, 1);
    a_clr = 1'b1; step(); a_clr = 1'b0;
    chk("ovf_clr", a_ovf, 0);

    // Drain, in order.
    for (int i = 0; i < 64; i++) a_cyc(1'b0, 8'h00, 1'b1);
    step();
`ifndef FIFO_FWFT_EN
    chk("dout_hold", a_dout, 8'h3F);
`endif
    chk("idle_valid", a_rv, 0);

    // Read while empty; then error beats simultaneous clear; then plain clear.
    a_cyc(1'b0, 8'h00, 1'b1);
    chk("udf_set", a_udf, 1);
    a_rd = 1'b1; a_clr = 1'b1; step(); a_rd = 1'b0; a_clr = 1'b0;
    chk("udf_err_wins", a_udf, 1);
    a_clr = 1'b1; step(); a_clr = 1'b0;
    chk("udf_clr", a_udf, 0);

    // Concurrent read/write at count 10.
    for (int i = 0; i < 10; i++) a_cyc(1'b1, 8'h40 + 8'(i), 1'b0);
    for (int k = 0; k < 20; k++) a_cyc(1'b1, 8'h50 + 8'(k), 1'b1);
    chk("conc_count", a_cnt, 10);
    for (int i = 0; i < 10; i++) a_cyc(1'b0, 8'h00, 1'b1);

    // Flush at count 7 with a write in the same cycle.
    for (int i = 0; i < 7; i++) a_cyc(1'b1, 8'h60 + 8'(i), 1'b0);
    a_flush = 1'b1; a_wr = 1'b1; a_din = 8'h77;
    step();
    a_flush = 1'b0; a_wr = 1'b0;
    qa.delete();
    chk("flush_count", a_cnt, 0);
    chk("flush_empty", a_empty, 1);
    chk("flush_aempty", a_ae, 1);
    chk("flush_ovf", a_ovf, 0);
    a_cyc(1'b1, 8'h12, 1'b0);
    a_cyc(1'b0, 8'h00, 1'b1);

    // Reset asserted in the middle of a write burst.
    for (int i = 0; i < 5; i++) a_cyc(1'b1, 8'h80 + 8'(i), 1'b0);
    a_cyc(1'b0, 8'h00, 1'b1);
    a_wr = 1'b1; a_din = 8'h99;
    step();
    rst_n = 1'b0;
    #1;
    chk("mrst_count", a_cnt, 0);
    chk("mrst_empty", a_empty, 1);
    chk("mrst_aempty", a_ae, 1);
    chk("mrst_full", a_full, 0);
    chk("mrst_valid", a_rv, 0);
`ifndef FIFO_FWFT_EN
    chk("mrst_dout", a_dout, 0);
`endif
    a_wr = 1'b0;
    qa.delete();
    step();
    rst_n = 1'b1;
    step();

    // Odd depth: 12 writes interleaved with reads across pointer wraps.
    for (int i = 0; i < 3; i++) b_cyc(1'b1, 8'hB0 + 8'(i), 1'b0);
    for (int i = 0; i < 2; i++) b_cyc(1'b0, 8'h00, 1'b1);
    for (int i = 3; i < 7; i++) b_cyc(1'b1, 8'hB0 + 8'(i), 1'b0);
    chk("b_full_at5", b_full, 1);
    for (int i = 0; i < 5; i++) b_cyc(1'b0, 8'h00, 1'b1);
    for (int i = 7; i < 12; i++) b_cyc(1'b1, 8'hB0 + 8'(i), 1'b1);
    for (int i = 0; i < 2; i++) b_cyc(1'b0, 8'h00, 1'b1);
    chk("b_ovf_none", b_ovf, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
